// File: rtl/mmio_periph.sv
// mmio_periph: memory-mapped peripheral block on the CPU data bus.
// Contains a reloadable 32-bit timer with interrupt, an 8-bit LED register
// and a scanned four-digit hex seven-segment display driver.
// Optional feature macro: MMIO_SYSTICK_EN adds a free-running SYSTICK
// counter at offset 0x14.
module mmio_periph #(
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
   parameter int unsigned SCAN_DIV  = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        memread,
   input  logic        memwrite,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        hit,
   output logic        irq,
   output logic [7:0]  led,
   output logic [6:0]  seg,
   output logic [3:0]  an
);

   localparam logic [19:0] SCAN_LAST = 20'(SCAN_DIV - 1);

   logic [31:0] th_reg, tl_reg, tl_next;
   logic [2:0]  tcon_reg, tcon_next;
   logic [7:0]  led_reg;
   logic [15:0] disp_reg, disp_next;
   logic [19:0] scan_cnt_reg;
   logic [1:0]  idx_reg, idx_next;
   logic [6:0]  seg_reg;
   logic [3:0]  an_reg;
   logic        scan_wrap, overflow;

   logic        in_window;
   logic [4:0]  offset;
   logic        sel_th, sel_tl, sel_tcon, sel_led, sel_disp, sel_tick;
   logic        addr_lo_unused;

`ifdef MMIO_SYSTICK_EN
   logic [31:0] systick_reg;
`endif

   // Word-aligned offset; byte-lane bits are not part of the decode.
   assign in_window      = (addr[31:5] == BASE_ADDR[31:5]);
   assign offset         = {addr[4:2], 2'b00};
   assign addr_lo_unused = ^addr[1:0];

   // Hex nibble to active-low segments (bit 6 = g ... bit 0 = a).
   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'b1000000;
         4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;
         4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;
         4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;
         4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b1000110;
         4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110;
         default: hex7 = 7'b0001110;
      endcase
   endfunction

   // Register select decode; only implemented offsets inside the window hit.
   always_comb begin
      sel_th   = 1'b0;
      sel_tl   = 1'b0;
      sel_tcon = 1'b0;
      sel_led  = 1'b0;
      sel_disp = 1'b0;
      sel_tick = 1'b0;
      if (in_window) begin
         case (offset)
            5'h00: sel_th   = 1'b1;
            5'h04: sel_tl   = 1'b1;
            5'h08: sel_tcon = 1'b1;
            5'h0C: sel_led  = 1'b1;
            5'h10: sel_disp = 1'b1;
`ifdef MMIO_SYSTICK_EN
            5'h14: sel_tick = 1'b1;
`endif
            default: ;
         endcase
      end
   end

   assign hit = sel_th | sel_tl | sel_tcon | sel_led | sel_disp | sel_tick;

   // Zero-latency read mux, gated by the read strobe.
   always_comb begin
      rdata = 32'h0;
      if (memread) begin
         if (sel_th)   rdata = th_reg;
         if (sel_tl)   rdata = tl_reg;
         if (sel_tcon) rdata = {29'h0, tcon_reg};
         if (sel_led)  rdata = {24'h0, led_reg};
         if (sel_disp) rdata = {16'h0, disp_reg};
`ifdef MMIO_SYSTICK_EN
         if (sel_tick) rdata = systick_reg;
`endif
      end
   end

   // Timer next state: CPU write to TL wins; a setting overflow is never lost.
   always_comb begin
      overflow  = tcon_reg[0] && (tl_reg == 32'hFFFF_FFFF);
      tl_next   = tl_reg;
      tcon_next = tcon_reg;
      if (tcon_reg[0]) tl_next = overflow ? th_reg : tl_reg + 32'd1;
      if (memwrite && sel_tl)   tl_next   = wdata;
      if (memwrite && sel_tcon) tcon_next = wdata[2:0];
      if (overflow && tcon_reg[1]) tcon_next[2] = 1'b1;
   end

   // Scanner next state; seg/an are computed from the post-edge index and DISP.
   always_comb begin
      scan_wrap = (scan_cnt_reg == SCAN_LAST);
      idx_next  = scan_wrap ? idx_reg + 2'd1 : idx_reg;
      disp_next = (memwrite && sel_disp) ? wdata[15:0] : disp_reg;
   end

   // Timer and software-visible registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         th_reg   <= 32'h0;
         tl_reg   <= 32'h0;
         tcon_reg <= 3'h0;
         led_reg  <= 8'h0;
         disp_reg <= 16'h0;
      end else begin
         if (memwrite && sel_th)  th_reg  <= wdata;
         if (memwrite && sel_led) led_reg <= wdata[7:0];
         tl_reg   <= tl_next;
         tcon_reg <= tcon_next;
         disp_reg <= disp_next;
      end
   end

   // Display scan counter, digit index and registered digit outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scan_cnt_reg <= 20'h0;
         idx_reg      <= 2'd0;
         seg_reg      <= 7'b1000000;
         an_reg       <= 4'b1110;
      end else begin
         scan_cnt_reg <= scan_wrap ? 20'h0 : scan_cnt_reg + 20'd1;
         idx_reg      <= idx_next;
         seg_reg      <= hex7(disp_next[{idx_next, 2'b00} +: 4]);
         an_reg       <= ~(4'b0001 << idx_next);
      end
   end

`ifdef MMIO_SYSTICK_EN
   // Free-running SYSTICK; a CPU write overrides the increment.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                      systick_reg <= 32'h0;
      else if (memwrite && sel_tick) systick_reg <= wdata;
      else                           systick_reg <= systick_reg + 32'd1;
   end
`endif

   assign irq = tcon_reg[2];
   assign led = led_reg;
   assign seg = seg_reg;
   assign an  = an_reg;

endmodule

// File: tb/tb_mmio_periph.sv
// tb_mmio_periph: self-checking bench for mmio_periph with a behavioural
// register-level model, directed scenarios and randomized bus traffic.
module tb_mmio_periph;

   localparam logic [31:0] BASE = 32'h4000_0000;
   localparam int SDIV = 4;
`ifdef MMIO_SYSTICK_EN
   localparam bit HAS_TICK = 1'b1;
`else
   localparam bit HAS_TICK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        memread = 1'b0;
   logic        memwrite = 1'b0;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic [31:0] rdata;
   logic        hit, irq;
   logic [7:0]  led;
   logic [6:0]  seg;
   logic [3:0]  an;

   always #5 clk = ~clk;

   mmio_periph #(.BASE_ADDR(BASE), .SCAN_DIV(SDIV)) dut (
      .clk(clk), .rst(rst), .memread(memread), .memwrite(memwrite),
      .addr(addr), .wdata(wdata), .rdata(rdata), .hit(hit), .irq(irq),
      .led(led), .seg(seg), .an(an)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [31:0] m_th, m_tl, m_tick;
   logic [2:0]  m_tcon;
   logic [7:0]  m_led;
   logic [15:0] m_disp;
   int          m_cycles;

   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit m_hit(input logic [31:0] a);
      logic [4:0] off;
      off = {a[4:2], 2'b00};
      if (a[31:5] != BASE[31:5]) return 1'b0;
      case (off)
         5'h00, 5'h04, 5'h08, 5'h0C, 5'h10: return 1'b1;
         5'h14: return HAS_TICK;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a);
      case ({a[4:2], 2'b00})
         5'h00: return m_th;
         5'h04: return m_tl;
         5'h08: return {29'h0, m_tcon};
         5'h0C: return {24'h0, m_led};
         5'h10: return {16'h0, m_disp};
         5'h14: return m_tick;
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_reset();
      m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_disp = 0; m_tick = 0; m_cycles = 0;
   endtask

   // One clock edge of the register-level behaviour.
   task automatic model_step(input logic wr, input logic [31:0] a, input logic [31:0] d);
      bit          w, ovf;
      logic [4:0]  off;
      logic [31:0] ntl;
      logic [2:0]  ntc;
      w   = wr && m_hit(a);
      off = {a[4:2], 2'b00};
      ovf = m_tcon[0] && (m_tl == 32'hFFFF_FFFF);
      ntl = m_tcon[0] ? (ovf ? m_th : m_tl + 1) : m_tl;
      ntc = m_tcon;
      if (w && off == 5'h04) ntl = d;
      if (w && off == 5'h08) ntc = d[2:0];
      if (ovf && m_tcon[1]) ntc[2] = 1'b1;
      if (w && off == 5'h00) m_th = d;
      if (w && off == 5'h0C) m_led = d[7:0];
      if (w && off == 5'h10) m_disp = d[15:0];
      m_tick = (w && off == 5'h14) ? d : m_tick + 1;
      m_tl = ntl;
      m_tcon = ntc;
      m_cycles++;
   endtask

   // One bus cycle: drive at negedge, compare all outputs, advance one edge.
   task automatic cyc(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] rv);
      int idx;
      logic [3:0] ea;
      memread = rd; memwrite = wr; addr = a; wdata = d;
      #1;
      idx = (m_cycles / SDIV) % 4;
      ea = 4'b1111;
      ea[idx] = 1'b0;
      check("hit", hit, m_hit(a));
      check("rdata", rdata, (rd && m_hit(a)) ? m_read(a) : 32'h0);
      check("irq", irq, m_tcon[2]);
      check("led", led, m_led);
      check("an", an, ea);
      check("seg", seg, seg_tab[m_disp[idx*4 +: 4]]);
      rv = rdata;
      @(posedge clk);
      model_step(wr, a, d);
      @(negedge clk);
      memread = 1'b0; memwrite = 1'b0;
   endtask

   task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
      logic [31:0] rv;
      cyc(1'b0, 1'b1, a, d, rv);
   endtask

   task automatic rd_reg(input logic [31:0] a, output logic [31:0] rv);
      cyc(1'b1, 1'b0, a, 32'h0, rv);
   endtask

   task automatic idle(input int n);
      logic [31:0] rv;
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 32'h0, rv);
   endtask

   // Assert reset between edges, check outputs while held, release at a negedge.
   task automatic do_reset();
      #2 rst = 1'b0;
      #1;
      check("rst_irq", irq, 32'h0);
      check("rst_led", led, 32'h0);
      check("rst_an", an, 32'hE);
      check("rst_seg", seg, 32'h40);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   initial begin
      logic [31:0] v, v2;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // Scanner walk with DISP = 3B0F
      wr_reg(BASE + 32'h10, 32'h3B0F);
      check("scan0_an", an, 32'hE);   check("scan0_seg", seg, 32'h0E);
      idle(3);
      check("scan1_an", an, 32'hD);   check("scan1_seg", seg, 32'h40);
      idle(4);
      check("scan2_an", an, 32'hB);   check("scan2_seg", seg, 32'h03);
      idle(4);
      check("scan3_an", an, 32'h7);   check("scan3_seg", seg, 32'h30);
      idle(4);
      check("scanw_an", an, 32'hE);   check("scanw_seg", seg, 32'h0E);

      // Decode
      rd_reg(BASE + 32'h4, v);
      check("dec_tl", v, 32'h0);
      memread = 1'b1; addr = 32'h4000_0018; #1;
      check("dec18_hit", hit, 32'h0); check("dec18_rdata", rdata, 32'h0);
      addr = 32'h5000_0000; #1;
      check("dec5_hit", hit, 32'h0);  check("dec5_rdata", rdata, 32'h0);
      memread = 1'b0;
      @(negedge clk);
      m_cycles++;
      wr_reg(BASE + 32'hC, 32'h1A5);
      check("led_out", led, 32'hA5);
      rd_reg(BASE + 32'hC, v);
      check("led_rd", v, 32'hA5);

      // Overflow and reload
      wr_reg(BASE + 32'h0, 32'hFFFF_FFFC);
      wr_reg(BASE + 32'h4, 32'hFFFF_FFFE);
      wr_reg(BASE + 32'h8, 32'h3);
      rd_reg(BASE + 32'h4, v); check("ovf_tl0", v, 32'hFFFF_FFFE);
      rd_reg(BASE + 32'h4, v); check("ovf_tl1", v, 32'hFFFF_FFFF);
      check("ovf_irq", irq, 32'h1);
      rd_reg(BASE + 32'h4, v); check("ovf_reload", v, 32'hFFFF_FFFC);
      wr_reg(BASE + 32'h8, 32'h3);
      check("irq_clr", irq, 32'h0);
      wr_reg(BASE + 32'h8, 32'h0);
      rd_reg(BASE + 32'h4, v); check("frz_a", v, 32'hFFFF_FFFF);
      rd_reg(BASE + 32'h4, v); check("frz_b", v, 32'hFFFF_FFFF);

      // Same-cycle conflicts
      wr_reg(BASE + 32'h4, 32'hFFFF_FFFE);
      wr_reg(BASE + 32'h8, 32'h3);
      idle(1);
      wr_reg(BASE + 32'h8, 32'h3);
      check("nolost_irq", irq, 32'h1);
      wr_reg(BASE + 32'h4, 32'h7);
      rd_reg(BASE + 32'h4, v); check("tlw_7", v, 32'h7);
      rd_reg(BASE + 32'h4, v); check("tlw_8", v, 32'h8);
      wr_reg(BASE + 32'h8, 32'h0);

      // Optional SYSTICK
`ifdef MMIO_SYSTICK_EN
      rd_reg(BASE + 32'h14, v);
      idle(9);
      rd_reg(BASE + 32'h14, v2);
      check("tick_delta", v2 - v, 32'd10);
      wr_reg(BASE + 32'h14, 32'hFFFF_FFFF);
      rd_reg(BASE + 32'h14, v); check("tick_max", v, 32'hFFFF_FFFF);
      rd_reg(BASE + 32'h14, v); check("tick_wrap", v, 32'h0);
`else
      memread = 1'b1; addr = BASE + 32'h14; #1;
      check("tick_hit", hit, 32'h0); check("tick_rdata", rdata, 32'h0);
      memread = 1'b0;
      wr_reg(BASE + 32'h14, 32'h1234);
`endif

      // Reset mid-run
      wr_reg(BASE + 32'h10, 32'hBEEF);
      wr_reg(BASE + 32'h4, 32'h5);
      wr_reg(BASE + 32'h8, 32'h7);
      idle(3);
      do_reset();
      rd_reg(BASE + 32'h4, v);  check("rst_tl", v, 32'h0);
      rd_reg(BASE + 32'h8, v);  check("rst_tcon", v, 32'h0);
      rd_reg(BASE + 32'hC, v);  check("rst_ledr", v, 32'h0);
      rd_reg(BASE + 32'h10, v); check("rst_disp", v, 32'h0);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         int r;
         logic [31:0] a, d;
         r = $urandom_range(0, 9);
         if (r < 8)       a = BASE + 32'(r * 4) + 32'($urandom_range(0, 3));
         else if (r == 8) a = 32'h5000_0000 + 32'($urandom_range(0, 31));
         else             a = $urandom;
         d = $urandom;
         if ((r == 1 || r == 5) && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), a, d, v);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mmio_periph.md
Name: mmio_periph

Overview:
- Memory-mapped peripheral responder on the CPU data-memory bus (memread/memwrite/address/write data).
- Sits beside the data memory. Top level selects `rdata` over data-memory read data when `hit`=1.
- Provides:
  - a 32-bit reloadable timer with interrupt request,
  - an 8-bit LED register,
  - a scanned 4-digit hex seven-segment display driver.

Parameters:
- BASE_ADDR, 32'h40000000, base of the 32-byte peripheral window; bits [4:0] are zero.
- SCAN_DIV, 50000, clock cycles each display digit is held; legal values 2 to 2^20.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- memread  in  1  CPU read strobe.
- memwrite  in  1  CPU write strobe.
- addr  in  32  byte address; bits [1:0] ignored.
- wdata  in  32  write data.
- rdata  out  32  read data, combinational.
- hit  out  1  high when addr decodes to an implemented register.
- irq  out  1  timer interrupt request (= TCON[2]).
- led  out  8  LED register value.
- seg  out  7  segment lines, active-low; bit 0 = a … bit 6 = g.
- an  out  4  digit enables, active-low, one-hot-low.

Behaviour:
- Address decode:
  - hit = (addr[31:5] == BASE_ADDR[31:5]) && (offset implemented).
  - hit is independent of memread/memwrite.
- Register map (offset = addr[4:0]):
  - 0x00 TH: 32-bit reload value, R/W.
  - 0x04 TL: 32-bit counter, R/W.
  - 0x08 TCON: bit0 enable, bit1 irq_en, bit2 status; bits[31:3] read 0. R/W.
  - 0x0C LED: bits[7:0], R/W; upper bits read 0.
  - 0x10 DISP: bits[15:0], four hex digits (digit0 = [3:0]), R/W.
  - 0x14 SYSTICK: optional, see below.
- Reads:
  - rdata = selected register when memread && hit; otherwise 32'h0.
  - Zero latency, pure combinational path from addr.
- Writes:
  - Take effect at the rising edge when memwrite && hit.
  - Writes to unimplemented offsets or outside the window are ignored.
- Reset (rst=0, asynchronous):
  - TH=0, TL=0, TCON=0, LED=0, DISP=0, scan counter=0, digit index=0.
  - Outputs: irq=0, led=0, an=4'b1110, seg=7'b1000000 (hex 0).
- Timer, per cycle when TCON[0]=1:
  - If TL==32'hFFFFFFFF: TL<=TH; status<=1 if irq_en=1.
  - Otherwise TL<=TL+1 (modulo 2^32).
  - When TCON[0]=0, TL holds.
- Timer priority:
  - CPU write to TL beats increment/reload in the same cycle.
  - CPU write to TCON updates bits 0,1 and bit 2; however, if an overflow that sets status occurs in the same cycle, status ends at 1 (no lost interrupt).
  - Writing status=1 by software is allowed and raises irq.
- Display scanner:
  - scan counter counts 0..SCAN_DIV-1 and wraps.
  - On wrap, digit index advances 0→1→2→3→0.
  - an[idx]=0, other enables 1.
  - seg = hex-to-7-seg of DISP nibble [4*idx+3:4*idx], active-low. Full 0-F table; A,b,C,d,E,F in standard forms.
  - seg and an are registered: they change on the same edge as the index.
  - A DISP write is reflected at the next edge on the currently selected digit.
- led = LED[7:0] register output directly.

Optional Feature:
- Macro: MMIO_SYSTICK_EN.
- Defined:
  - Offset 0x14 is implemented (hit=1).
  - SYSTICK is a 32-bit free-running counter, reset 0, +1 every cycle, wraps at 2^32.
  - Read returns the current value.
  - A write loads wdata, and the write wins over the increment that cycle.
- Undefined:
  - Offset 0x14 is unimplemented: hit=0, rdata=0, writes ignored, no counter logic.

Test Plan:
- Reset mid-run: run timer with TL=5, assert rst=0 between edges → TL, TCON, LED, DISP read 0 immediately after release; an=4'b1110, seg=7'b1000000, irq=0.
- Overflow: write TH=32'hFFFFFFFC, TL=32'hFFFFFFFE, TCON=3 → TL reads FFFFFFFF, then FFFFFFFC on the next cycle; irq=1 from that edge; write TCON=3 clears irq; write TCON=0 freezes TL.
- Same-cycle conflicts: TL=FFFFFFFF with TCON=3, write TCON=3 on the overflow edge → status stays 1. Separately, write TL=7 while counting → TL reads 7, then 8.
- Decode: addr 40000004 reads TL with hit=1; addr 40000018 and 50000000 give hit=0, rdata=0; write LED=32'h1A5 → led=8'hA5, reads back 000000A5.
- Scanner with SCAN_DIV=4: write DISP=16'h3B0F → digit0 seg=7'b0001110 (F) with an=1110; after 4 cycles an=1101, seg=1000000 (0); then 1011/0000011 (b); then 0111/0110000 (3); then back to digit0.
- MMIO_SYSTICK_EN both builds: defined → two reads 10 cycles apart differ by 10, write 32'hFFFFFFFF then wraps to 0; undefined → 0x14 gives hit=0, rdata=0.
